pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush controller for the five-stage in-order pipeline. Collects stall requests from IF, ID, EX and MEM and flush requests from EX (branch mispredict) and WB (exception/ertn). Produces one 2-bit control code per pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB), plus per-register flush pulses. Tracks the outstanding I-cache fetch so that a response to a fetch issued before a flush is dropped.

## Interface
- No parameters.
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `if_stall` in 1: IF not ready (I-cache miss).
- `id_stall` in 1: load-use hazard.
- `ex_stall` in 1: multicycle unit busy.
- `mem_stall` in 1: D-cache miss.
- `ex_br_flush` in 1: branch mispredict resolved in EX.
- `wb_excp_flush` in 1: exception or ertn committed in WB.
- `if_req_fire` in 1: I-cache accepted a fetch request this cycle.
- `if_resp_valid` in 1: I-cache returns fetch data this cycle.
- `pc_ctl`, `ifid_ctl`, `idex_ctl`, `exmem_ctl`, `memwb_ctl` out 2: register control codes.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1: register flush.
- `flush_cause` out 1: 1 = WB exception/ertn, 0 = EX branch.
- `if_resp_drop` out 1: discard the current I-cache response.

## Operation
- Control code: 2'b10 = advance (load input); 2'b11 = bubble (load NOP, issue 2'b11); 2'b00 = hold. The controller never drives 2'b01.
- Stall resolution: the oldest active source wins, in the order MEM > EX > ID > IF_eff.
  - `if_eff` = `if_stall` | (state == DROP).
  - The stalled stage's output register gets a bubble.
  - All registers between PC and that stage hold.
  - All older registers advance.
  - MEM stall: pc/ifid/idex/exmem = 00, memwb = 11.
  - EX stall: pc/ifid/idex = 00, exmem = 11, memwb = 10.
  - ID stall: pc/ifid = 00, idex = 11, exmem/memwb = 10.
  - IF_eff stall: pc = 00, ifid = 11, rest = 10.
  - No stall: all 10.
- Flush handling:
  - `wb_excp_flush` asserts all four `*_flush` signals and sets `flush_cause` = 1.
  - `ex_br_flush` alone asserts `ifid_flush` and `idex_flush` and sets `flush_cause` = 0.
  - WB dominates when both flush sources are active.
  - A flushed register's flush overrides its ctl code.
  - `pc_ctl` = 10 on any flush.
  - Stalls from stages younger than the flush source are ignored.
  - `mem_stall` is ignored during a WB flush.
  - During an EX flush, `mem_stall` is still honoured for exmem/memwb only.
- Fetch FSM states:
  - IDLE -> BUSY on `if_req_fire`.
  - BUSY & `if_resp_valid` & !flush -> IDLE, or stays BUSY if `if_req_fire` in the same cycle.
  - BUSY & flush & !`if_resp_valid` -> DROP.
  - BUSY & flush & `if_resp_valid` -> IDLE. The response is killed by `ifid_flush`; `if_resp_drop` = 0.
  - DROP & `if_resp_valid` -> IDLE, with `if_resp_drop` = 1 that cycle.
  - A flush while in DROP keeps DROP.
  - `if_req_fire` while in DROP is a protocol error: ignored, and flagged by a simulation-only assertion.
- A flush during DROP still drives `pc_ctl` = 10 so the redirect PC loads. Fetch stays blocked via `if_eff` until DROP exits.

## Timing
- All ctl, flush and `if_resp_drop` outputs are combinational from the current-cycle inputs and the FSM state. Latency is 0 cycles.
- Only the FSM state (and the counters, when enabled) is registered, updated on the rising edge of `aclk`.
- While `aresetn` = 0:
  - state = IDLE;
  - all ctl outputs = 2'b00;
  - all flush outputs = 0, `flush_cause` = 0, `if_resp_drop` = 0;
  - counters = 0.
- Reset assertion mid-fetch returns the FSM to IDLE immediately. Any later stray response is the I-cache's responsibility (the I-cache is also reset).
- On the first edge after reset release, the FSM evaluates normally.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: adds outputs `perf_stall_cyc` out 32 and `perf_flush_cnt` out 32, both reset to 0.
  - `perf_stall_cyc` increments on every cycle where `pc_ctl` = 00.
  - `perf_flush_cnt` increments on every cycle with any flush.
  - Both wrap modulo 2^32 (0xFFFFFFFF -> 0).
- Undefined: ports and counters are absent. Stall/flush behaviour is identical.

## Test plan
- Reset low, all inputs 1 -> all ctl = 00, all flush = 0. After release with only `if_req_fire` = 1 -> next cycle state BUSY, all ctl = 10.
- `mem_stall` = 1 and `id_stall` = 1 -> pc/ifid/idex/exmem = 00, memwb = 11. Drop `mem_stall` -> pc/ifid = 00, idex = 11, exmem/memwb = 10.
- `ex_br_flush` = 1 and `wb_excp_flush` = 1 together -> all four flushes = 1, `flush_cause` = 1. `ex_br_flush` alone with `mem_stall` = 1 -> ifid/idex flush = 1, exmem = 00, memwb = 11, `flush_cause` = 0.
- Enter BUSY, assert `ex_br_flush` with no response -> DROP, ifid = 11 on following cycles. Response 3 cycles later -> `if_resp_drop` = 1 for exactly that cycle, then IDLE with ifid = 10.
- In BUSY, assert flush and `if_resp_valid` in the same cycle -> `if_resp_drop` = 0, `ifid_flush` = 1, next state IDLE.
- With `PIPE_CTRL_PERF_EN`: preload `perf_stall_cyc` = 0xFFFFFFFF by force, hold `if_stall` one cycle -> counter wraps to 0. Two flush cycles -> `perf_flush_cnt` = 2.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush request and control bundle between the pipeline
// stages (master) and the central stall/flush controller (slave).
//   Requests : if_stall, id_stall, ex_stall, mem_stall, ex_br_flush,
//              wb_excp_flush, if_req_fire, if_resp_valid
//   Controls : pc/ifid/idex/exmem/memwb_ctl (2b: 10 adv, 11 bubble, 00 hold),
//              ifid/idex/exmem/memwb_flush, flush_cause, if_resp_drop
interface pipe_ctrl_if;
  logic       if_stall;
  logic       id_stall;
  logic       ex_stall;
  logic       mem_stall;
  logic       ex_br_flush;
  logic       wb_excp_flush;
  logic       if_req_fire;
  logic       if_resp_valid;
  logic [1:0] pc_ctl;
  logic [1:0] ifid_ctl;
  logic [1:0] idex_ctl;
  logic [1:0] exmem_ctl;
  logic [1:0] memwb_ctl;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       memwb_flush;
  logic       flush_cause;
  logic       if_resp_drop;

  modport master (
    output if_stall, id_stall, ex_stall, mem_stall, ex_br_flush,
           wb_excp_flush, if_req_fire, if_resp_valid,
    input  pc_ctl, ifid_ctl, idex_ctl, exmem_ctl, memwb_ctl,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           flush_cause, if_resp_drop
  );

  modport slave (
    input  if_stall, id_stall, ex_stall, mem_stall, ex_br_flush,
           wb_excp_flush, if_req_fire, if_resp_valid,
    output pc_ctl, ifid_ctl, idex_ctl, exmem_ctl, memwb_ctl,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           flush_cause, if_resp_drop
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage in-order pipeline.
// Resolves stage stall requests (oldest wins: MEM > EX > ID > IF) and flush
// requests (WB exception/ertn dominates EX branch mispredict) into per-register
// control codes and flush pulses, and tracks the outstanding I-cache fetch so
// a response belonging to a pre-flush fetch is dropped.
//   aclk     : clock
//   aresetn  : asynchronous active-low reset (all outputs forced to 0 while low)
//   bus      : pipe_ctrl_if.slave (requests in, controls out)
//   perf_stall_cyc / perf_flush_cnt : 32b counters, present only when
//              PIPE_CTRL_PERF_EN is defined
module pipe_ctrl (
  input  logic        aclk,
  input  logic        aresetn,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
`endif
  pipe_ctrl_if.slave  bus
);

  localparam logic [1:0] CTL_ADV  = 2'b10;
  localparam logic [1:0] CTL_BUB  = 2'b11;
  localparam logic [1:0] CTL_HOLD = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_flush;
  logic       w_if_eff;
  logic [1:0] w_pc, w_ifid, w_idex, w_exmem, w_memwb;
  logic       w_ifid_fl, w_idex_fl, w_exmem_fl, w_memwb_fl, w_cause;

  assign w_flush  = bus.wb_excp_flush | bus.ex_br_flush;
  // A fetch whose response must be discarded blocks IF like a cache miss.
  assign w_if_eff = bus.if_stall | (r_state == S_DROP);

  always_comb begin
    w_pc       = CTL_ADV;
    w_ifid     = CTL_ADV;
    w_idex     = CTL_ADV;
    w_exmem    = CTL_ADV;
    w_memwb    = CTL_ADV;
    w_ifid_fl  = 1'b0;
    w_idex_fl  = 1'b0;
    w_exmem_fl = 1'b0;
    w_memwb_fl = 1'b0;
    w_cause    = 1'b0;
    if (bus.wb_excp_flush) begin
      // Everything younger than WB is squashed; no stall can matter.
      w_ifid_fl  = 1'b1;
      w_idex_fl  = 1'b1;
      w_exmem_fl = 1'b1;
      w_memwb_fl = 1'b1;
      w_cause    = 1'b1;
      w_ifid     = CTL_BUB;
      w_idex     = CTL_BUB;
      w_exmem    = CTL_BUB;
      w_memwb    = CTL_BUB;
    end else if (bus.ex_br_flush) begin
      // Front end is squashed and redirected; only MEM (older) may still stall.
      w_ifid_fl = 1'b1;
      w_idex_fl = 1'b1;
      w_ifid    = CTL_BUB;
      w_idex    = CTL_BUB;
      if (bus.mem_stall) begin
        w_exmem = CTL_HOLD;
        w_memwb = CTL_BUB;
      end
    end else if (bus.mem_stall) begin
      w_pc    = CTL_HOLD;
      w_ifid  = CTL_HOLD;
      w_idex  = CTL_HOLD;
      w_exmem = CTL_HOLD;
      w_memwb = CTL_BUB;
    end else if (bus.ex_stall) begin
      w_pc    = CTL_HOLD;
      w_ifid  = CTL_HOLD;
      w_idex  = CTL_HOLD;
      w_exmem = CTL_BUB;
    end else if (bus.id_stall) begin
      w_pc   = CTL_HOLD;
      w_ifid = CTL_HOLD;
      w_idex = CTL_BUB;
    end else if (w_if_eff) begin
      w_pc   = CTL_HOLD;
      w_ifid = CTL_BUB;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (bus.if_req_fire) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (w_flush)
          // A same-cycle response is killed by ifid_flush, nothing to drop later.
          w_state_nxt = bus.if_resp_valid ? S_IDLE : S_DROP;
        else if (bus.if_resp_valid)
          w_state_nxt = bus.if_req_fire ? S_BUSY : S_IDLE;
      end
      S_DROP: if (bus.if_resp_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  assign bus.pc_ctl       = aresetn ? w_pc    : '0;
  assign bus.ifid_ctl     = aresetn ? w_ifid  : '0;
  assign bus.idex_ctl     = aresetn ? w_idex  : '0;
  assign bus.exmem_ctl    = aresetn ? w_exmem : '0;
  assign bus.memwb_ctl    = aresetn ? w_memwb : '0;
  assign bus.ifid_flush   = aresetn & w_ifid_fl;
  assign bus.idex_flush   = aresetn & w_idex_fl;
  assign bus.exmem_flush  = aresetn & w_exmem_fl;
  assign bus.memwb_flush  = aresetn & w_memwb_fl;
  assign bus.flush_cause  = aresetn & w_cause;
  assign bus.if_resp_drop = aresetn & (r_state == S_DROP) & bus.if_resp_valid;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall_cyc;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_perf_stall_cyc <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (bus.pc_ctl == CTL_HOLD) r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
      if (w_flush)                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cyc = r_perf_stall_cyc;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

`ifndef SYNTHESIS
  a_no_req_in_drop: assert property (@(posedge aclk) disable iff (!aresetn)
    !(r_state == S_DROP && bus.if_req_fire))
    else $error("pipe_ctrl: if_req_fire while a stale fetch is outstanding");
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  pipe_ctrl_if bus();
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;
`endif

  pipe_ctrl dut (
    .aclk    (aclk),
    .aresetn (aresetn),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] ALL_ADV = 10'b10_10_10_10_10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctl_vec();
    return {bus.pc_ctl, bus.ifid_ctl, bus.idex_ctl, bus.exmem_ctl, bus.memwb_ctl};
  endfunction

  function automatic logic [4:0] fl_vec();
    return {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush, bus.flush_cause};
  endfunction

  task automatic set_in(input logic [5:0] v);
    {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall,
     bus.ex_br_flush, bus.wb_excp_flush} = v;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic [5:0] in;    // {if, id, ex, mem, br, wb}
    logic [9:0] ctl;   // {pc, ifid, idex, exmem, memwb}
    logic [9:0] care;  // ctl bits that are defined for this vector
    logic [4:0] fl;    // {ifid, idex, exmem, memwb flush, cause}
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{6'b000000, ALL_ADV,                10'h3FF,        5'b00000};
    vecs[1]  = '{6'b100000, 10'b00_11_10_10_10,     10'h3FF,        5'b00000};
    vecs[2]  = '{6'b010000, 10'b00_00_11_10_10,     10'h3FF,        5'b00000};
    vecs[3]  = '{6'b110000, 10'b00_00_11_10_10,     10'h3FF,        5'b00000};
    vecs[4]  = '{6'b111000, 10'b00_00_00_11_10,     10'h3FF,        5'b00000};
    vecs[5]  = '{6'b010100, 10'b00_00_00_00_11,     10'h3FF,        5'b00000};
    vecs[6]  = '{6'b111100, 10'b00_00_00_00_11,     10'h3FF,        5'b00000};
    vecs[7]  = '{6'b000011, 10'b10_00_00_00_00,     10'b1100000000, 5'b11111};
    vecs[8]  = '{6'b000110, 10'b10_00_00_00_11,     10'b1100001111, 5'b11000};
    vecs[9]  = '{6'b000010, 10'b10_00_00_10_10,     10'b1100001111, 5'b11000};
    vecs[10] = '{6'b111010, 10'b10_00_00_10_10,     10'b1100001111, 5'b11000};
    vecs[11] = '{6'b111101, 10'b10_00_00_00_00,     10'b1100000000, 5'b11111};

    // Reset with every input high: everything must read as zero.
    set_in(6'b111111);
    bus.if_req_fire = 1'b1;
    bus.if_resp_valid = 1'b1;
    #12;
    chk("reset_ctl", 32'(ctl_vec()), 32'h0);
    chk("reset_flush", 32'(fl_vec()), 32'h0);
    chk("reset_drop", 32'(bus.if_resp_drop), 32'h0);
    set_in('0);
    bus.if_req_fire = 1'b0;
    bus.if_resp_valid = 1'b0;
    step();
    aresetn = 1'b1;
    step();

    // Combinational stall/flush resolution from IDLE.
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].in);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_vec() & vecs[i].care), 32'(vecs[i].ctl & vecs[i].care));
      chk($sformatf("vec%0d_flush", i), 32'(fl_vec()), 32'(vecs[i].fl));
      #1;
    end
    set_in('0);
    step();

    // A: fetch, flush with no response -> DROP; stale response 3 cycles later.
    bus.if_req_fire = 1'b1; #1;
    chk("A_fire_ctl", 32'(ctl_vec()), 32'(ALL_ADV));
    step(); bus.if_req_fire = 1'b0;
    set_in(6'b000010); #1;
    chk("A_flush_pc", 32'(bus.pc_ctl), 32'h2);
    step(); set_in('0); #1;
    chk("A_drop1_ifid", 32'(bus.ifid_ctl), 32'h3);
    chk("A_drop1_pc", 32'(bus.pc_ctl), 32'h0);
    chk("A_drop1_nodrop", 32'(bus.if_resp_drop), 32'h0);
    step();
    chk("A_drop2_ifid", 32'(bus.ifid_ctl), 32'h3);
    step(); bus.if_resp_valid = 1'b1; #1;
    chk("A_resp_drop", 32'(bus.if_resp_drop), 32'h1);
    step(); bus.if_resp_valid = 1'b0; #1;
    chk("A_after_drop", 32'(bus.if_resp_drop), 32'h0);
    chk("A_idle_ctl", 32'(ctl_vec()), 32'(ALL_ADV));

    // B: flush and response in the same BUSY cycle -> no drop, back to IDLE.
    bus.if_req_fire = 1'b1;
    step(); bus.if_req_fire = 1'b0;
    set_in(6'b000010); bus.if_resp_valid = 1'b1; #1;
    chk("B_drop", 32'(bus.if_resp_drop), 32'h0);
    chk("B_ifid_flush", 32'(bus.ifid_flush), 32'h1);
    step(); set_in('0); bus.if_resp_valid = 1'b0; #1;
    chk("B_idle_ifid", 32'(bus.ifid_ctl), 32'h2);

    // C: response with back-to-back request keeps BUSY; a later flush -> DROP.
    bus.if_req_fire = 1'b1;
    step(); bus.if_resp_valid = 1'b1;
    step(); bus.if_req_fire = 1'b0; bus.if_resp_valid = 1'b0;
    set_in(6'b000010);
    step(); set_in('0); #1;
    chk("C_drop_ifid", 32'(bus.ifid_ctl), 32'h3);
    bus.if_resp_valid = 1'b1; #1;
    chk("C_resp_drop", 32'(bus.if_resp_drop), 32'h1);
    step(); bus.if_resp_valid = 1'b0;

    // D: response without flush -> IDLE; a flush in IDLE leaves it IDLE.
    bus.if_req_fire = 1'b1;
    step(); bus.if_req_fire = 1'b0; bus.if_resp_valid = 1'b1;
    step(); bus.if_resp_valid = 1'b0; set_in(6'b000010);
    step(); set_in('0); #1;
    chk("D_idle_ifid", 32'(bus.ifid_ctl), 32'h2);

    // E: a WB flush while in DROP redirects PC but fetch stays blocked.
    bus.if_req_fire = 1'b1;
    step(); bus.if_req_fire = 1'b0; set_in(6'b000010);
    step(); set_in(6'b000001); #1;
    chk("E_pc_redirect", 32'(bus.pc_ctl), 32'h2);
    chk("E_flush", 32'(fl_vec()), 32'h1F);
    step(); set_in('0); #1;
    chk("E_still_drop", 32'(bus.ifid_ctl), 32'h3);
    bus.if_resp_valid = 1'b1;
    step(); bus.if_resp_valid = 1'b0;

    // F: reset while in DROP returns to IDLE immediately.
    bus.if_req_fire = 1'b1;
    step(); bus.if_req_fire = 1'b0; set_in(6'b000010);
    step(); set_in('0);
    #1; aresetn = 1'b0; #1;
    chk("F_reset_ctl", 32'(ctl_vec()), 32'h0);
    #1; aresetn = 1'b1; #1;
    chk("F_idle_ifid", 32'(bus.ifid_ctl), 32'h2);
    bus.if_resp_valid = 1'b1; #1;
    chk("F_no_drop", 32'(bus.if_resp_drop), 32'h0);
    step(); bus.if_resp_valid = 1'b0;

`ifdef PIPE_CTRL_PERF_EN
    aresetn = 1'b0; #2; aresetn = 1'b1;
    step();
    set_in(6'b000010); step(); step(); set_in('0); #1;
    chk("P_flush_cnt", perf_flush_cnt, 32'd2);
    force dut.r_perf_stall_cyc = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_stall_cyc;
    set_in(6'b100000);
    step(); set_in('0); #1;
    chk("P_stall_wrap", perf_stall_cyc, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
